// File: rtl/scarv_axi_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// scarv_axi_arbiter_2to1
//
// Two-master to one-slave AXI4-lite arbiter. Port 0 is the PicoRV32 master,
// port 1 is the XCrypto COP master; both share a single downstream memory port.
// Only one transaction (read or write) is outstanding across the whole system.
//
// Parameters:
//   FIXED_PRIO : 1 = port 0 always wins a tie, 0 = round-robin on ties.
//   RST_LAST   : port treated as last-granted after reset (1 -> port 0 wins
//                the first tie).
//
// Ports:
//   g_clk, g_reset          : clock, asynchronous active-high reset.
//   s{0,1}_aw*/w*/b*/ar*/r* : upstream AXI4-lite slave interfaces.
//   m_aw*/w*/b*/ar*/r*      : downstream shared AXI4-lite master interface.
//
// Address, data, strobe and prot outputs always follow the granted port;
// only valids and readys are gated by the transaction state.
// -----------------------------------------------------------------------------
module scarv_axi_arbiter_2to1 #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit RST_LAST   = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [31:0] s0_awaddr,
    input  logic [2:0]  s0_awprot,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_bvalid,
    input  logic        s0_bready,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    input  logic [31:0] s0_araddr,
    input  logic [2:0]  s0_arprot,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    output logic [31:0] s0_rdata,

    input  logic        s1_awvalid,
    output logic        s1_awready,
    input  logic [31:0] s1_awaddr,
    input  logic [2:0]  s1_awprot,
    input  logic        s1_wvalid,
    output logic        s1_wready,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic        s1_bvalid,
    input  logic        s1_bready,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    input  logic [31:0] s1_araddr,
    input  logic [2:0]  s1_arprot,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] s1_rdata,

    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_B    = 3'd4
    } state_t;

    state_t state_r, state_nxt_s;
    logic   gnt_r, gnt_nxt_s;
    logic   last_r, last_nxt_s;
    logic   aw_done_r, aw_done_nxt_s;
    logic   w_done_r, w_done_nxt_s;

    logic   req0_s, req1_s, win_s, win_wr_s;
    logic   sel_awvalid_s, sel_wvalid_s, sel_arvalid_s, sel_bready_s, sel_rready_s;
    logic   awready_s, wready_s, arready_s, bvalid_s, rvalid_s;
    logic   aw_hs_s, w_hs_s, aw_cpl_s, w_cpl_s;

    // A port requests when it has either address channel valid; write wins within a port.
    assign req0_s   = s0_awvalid | s0_arvalid;
    assign req1_s   = s1_awvalid | s1_arvalid;
    assign win_wr_s = win_s ? s1_awvalid : s0_awvalid;

    // Payloads follow the granted port unconditionally.
    assign m_awaddr = gnt_r ? s1_awaddr : s0_awaddr;
    assign m_awprot = gnt_r ? s1_awprot : s0_awprot;
    assign m_wdata  = gnt_r ? s1_wdata  : s0_wdata;
    assign m_wstrb  = gnt_r ? s1_wstrb  : s0_wstrb;
    assign m_araddr = gnt_r ? s1_araddr : s0_araddr;
    assign m_arprot = gnt_r ? s1_arprot : s0_arprot;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

    assign sel_awvalid_s = gnt_r ? s1_awvalid : s0_awvalid;
    assign sel_wvalid_s  = gnt_r ? s1_wvalid  : s0_wvalid;
    assign sel_arvalid_s = gnt_r ? s1_arvalid : s0_arvalid;
    assign sel_bready_s  = gnt_r ? s1_bready  : s0_bready;
    assign sel_rready_s  = gnt_r ? s1_rready  : s0_rready;

    // Routed channel signals reach only the granted port.
    assign s0_awready = awready_s & ~gnt_r;
    assign s1_awready = awready_s &  gnt_r;
    assign s0_wready  = wready_s  & ~gnt_r;
    assign s1_wready  = wready_s  &  gnt_r;
    assign s0_arready = arready_s & ~gnt_r;
    assign s1_arready = arready_s &  gnt_r;
    assign s0_bvalid  = bvalid_s  & ~gnt_r;
    assign s1_bvalid  = bvalid_s  &  gnt_r;
    assign s0_rvalid  = rvalid_s  & ~gnt_r;
    assign s1_rvalid  = rvalid_s  &  gnt_r;

    assign aw_hs_s  = m_awvalid & m_awready;
    assign w_hs_s   = m_wvalid  & m_wready;
    assign aw_cpl_s = aw_done_r | aw_hs_s;
    assign w_cpl_s  = w_done_r  | w_hs_s;

    // Grant decision: a lone requester wins; a tie goes to port 0 or to the port not granted last.
    always_comb begin
        win_s = 1'b0;
        if (req0_s && req1_s) begin
            win_s = FIXED_PRIO ? 1'b0 : ~last_r;
        end else if (req1_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Channel gating: only the channels of the active phase pass valid/ready through.
    always_comb begin
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        arready_s = 1'b0;
        bvalid_s  = 1'b0;
        rvalid_s  = 1'b0;
        case (state_r)
            ST_AR: begin
                m_arvalid = sel_arvalid_s;
                arready_s = m_arready;
            end
            ST_R: begin
                rvalid_s = m_rvalid;
                m_rready = sel_rready_s;
            end
            ST_AW: begin
                // Done flags stop a completed address or data beat being re-issued.
                m_awvalid = sel_awvalid_s & ~aw_done_r;
                awready_s = m_awready & ~aw_done_r;
                m_wvalid  = sel_wvalid_s & ~w_done_r;
                wready_s  = m_wready & ~w_done_r;
            end
            ST_B: begin
                bvalid_s = m_bvalid;
                m_bready = sel_bready_s;
            end
            default: begin
                m_arvalid = 1'b0;
            end
        endcase
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_nxt_s     = gnt_r;
        last_nxt_s    = last_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    gnt_nxt_s   = win_s;
                    last_nxt_s  = win_s;
                    state_nxt_s = win_wr_s ? ST_AW : ST_AR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (m_arvalid && m_arready) begin
                    state_nxt_s = ST_R;
                end else begin
                    state_nxt_s = ST_AR;
                end
            end
            ST_R: begin
                if (m_rvalid && m_rready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_R;
                end
            end
            ST_AW: begin
                // Address and data may complete in either order or together.
                if (aw_cpl_s && w_cpl_s) begin
                    state_nxt_s   = ST_B;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s   = ST_AW;
                    aw_done_nxt_s = aw_cpl_s;
                    w_done_nxt_s  = w_cpl_s;
                end
            end
            ST_B: begin
                if (m_bvalid && m_bready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                aw_done_nxt_s = 1'b0;
                w_done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 1'b0;
            last_r    <= RST_LAST;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            last_r    <= last_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
        end
    end

endmodule

// File: doc/scarv_axi_arbiter_2to1.md
Name: scarv_axi_arbiter_2to1

Overview:
- Two-master to one-slave AXI4-lite arbiter.
- Merges the PicoRV32 AXI master and the XCrypto COP AXI master into a single shared memory port.
- Sits directly downstream of the integrated CPU/COP top, taking its prv_axi_* and cop_axi_* buses.
- One transaction (read or write) outstanding system-wide; round-robin or fixed-priority grant.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins a tie; 0 = round-robin.
- RST_LAST, 1, index of the port treated as last-granted after reset, so port 0 wins the first tie.

Ports:
- g_clk  in  1  global clock; all state updates on its rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- s{0,1}_awvalid/awready  in/out  1  write address handshake (port 0 = PicoRV32, port 1 = COP).
- s{0,1}_awaddr  in  32  write address.
- s{0,1}_awprot  in  3  write protection.
- s{0,1}_wvalid/wready  in/out  1  write data handshake.
- s{0,1}_wdata  in  32  write data.
- s{0,1}_wstrb  in  4  write byte strobes.
- s{0,1}_bvalid/bready  out/in  1  write response handshake.
- s{0,1}_arvalid/arready  in/out  1  read address handshake.
- s{0,1}_araddr  in  32  read address.
- s{0,1}_arprot  in  3  read protection.
- s{0,1}_rvalid/rready  out/in  1  read data handshake.
- s{0,1}_rdata  out  32  read data, equal to m_rdata.
- m_awvalid/awready, m_wvalid/wready, m_arvalid/arready  out/in  1  shared master-side handshakes.
- m_bvalid/rvalid  in  1  shared-port responses.
- m_bready/rready  out  1  shared-port response acceptance.
- m_awaddr, m_araddr  out  32  shared-port addresses.
- m_awprot, m_arprot  out  3  shared-port protection.
- m_wdata  out  32  shared-port write data.
- m_wstrb  out  4  shared-port byte strobes.
- m_rdata  in  32  shared-port read data.

Behaviour:
- Registers:
  - state: IDLE, AR, R, AW, B.
  - gnt (1 bit).
  - last (1 bit).
  - aw_done, w_done.
- Reset (asynchronous, immediate):
  - state=IDLE, gnt=0, last=RST_LAST, aw_done=w_done=0.
  - Every valid and ready output is 0.
  - Address/data outputs mux port gnt, i.e. port 0 in reset.
- Request per port: wr_req = awvalid; rd_req = arvalid. If both are set, write wins within that port.
- IDLE, grant decision:
  - Exactly one port requesting: grant it.
  - Both requesting and FIXED_PRIO=0: grant !last.
  - Both requesting and FIXED_PRIO=1: grant port 0.
  - On grant: gnt<=winner, last<=winner; next state AW (write) or AR (read).
  - No readys asserted in IDLE.
  - Minimum latency: request in cycle N, m_*valid in cycle N+1.
- AR:
  - m_arvalid = s[gnt]_arvalid; s[gnt]_arready = m_arready.
  - On m_arvalid & m_arready go to R.
- R:
  - s[gnt]_rvalid = m_rvalid; m_rready = s[gnt]_rready.
  - Handshake goes to IDLE.
  - Back-pressure holds state.
- AW:
  - m_awvalid = s[gnt]_awvalid & !aw_done; m_wvalid = s[gnt]_wvalid & !w_done; readys routed likewise.
  - Each handshake sets its done flag.
  - When both are complete (same cycle or different cycles): go to B and clear both flags.
  - Address is never re-issued after aw_done.
- B:
  - s[gnt]_bvalid = m_bvalid; m_bready = s[gnt]_bready.
  - Handshake goes to IDLE.
- Non-granted port and non-active channels: all readys/valids 0.
- Address/wdata/wstrb/prot always follow port gnt; only the valids are gated.
- Return to IDLE always costs one cycle before the next grant.
- Unexpected m_rvalid/m_bvalid outside R/B is ignored and not forwarded.

Test Plan:
- Single read: s0 araddr=0x1000 at cycle 0 -> m_arvalid=1 with m_araddr=0x1000 at cycle 1; m_rdata=0xDEADBEEF returned on s0_rvalid; s1_rvalid stays 0.
- Simultaneous after reset (s0 read 0x10, s1 write 0x20/0xCAFEF00D), both held -> s0 served first, then s1. Then both re-request -> s0 granted again (last=1), confirming alternation.
- Split write: m_awready at cycle 1, m_wready at cycle 3 -> exactly one s1_awready pulse; m_awvalid deasserts after cycle 1; B entered only after cycle 3.
- Read back-pressure: m_rvalid=1 with s0_rready=0 for 3 cycles -> m_rready=0 and state R held; rvalid handshake completes on cycle 4.
- Async reset asserted mid-AW (aw_done=1) -> all valids/readys 0 in the same cycle. After release, a pending s0 request gets its address re-issued.
- FIXED_PRIO=1 with both ports continuously requesting reads -> s0 granted on 5 consecutive transactions, s1 never granted.
